net_dr2core_snack: RTL

Return-path network from the two directory banks to the eight L2 pipes of a dual-core system. It carries snack messages (fills, acks, snoops) from dr0/dr1 to the L2 pipes c0_l2i, c0_l2it, c0_l2d_0, c0_l2dt_0, c1_l2i, c1_l2it, c1_l2d_0 and c1_l2dt_0. Any directory can reach any L2 pipe. Each input is buffered, each destination has its own round-robin arbiter and an output register, and all handshakes are valid/retry.

---
 rtl/net_dr2core_snack.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/net_dr2core_snack.sv
// Return-path snack network: two directory input FIFOs feeding eight L2-pipe
// output registers, each pipe with its own two-way round-robin arbiter.
module net_dr2core_snack #(
    parameter int SNACK_W  = 128,
    parameter int DST_LSB  = 0,
    parameter int IN_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   dr0tol2_snack_valid,
    output logic                   dr0tol2_snack_retry,
    input  logic [SNACK_W-1:0]     dr0tol2_snack,
    input  logic                   dr1tol2_snack_valid,
    output logic                   dr1tol2_snack_retry,
    input  logic [SNACK_W-1:0]     dr1tol2_snack,
    output logic [7:0]             drtol2_snack_valid,
    input  logic [7:0]             drtol2_snack_retry,
    output logic [8*SNACK_W-1:0]   drtol2_snack
);

    localparam int PW = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(IN_DEPTH);

    logic [1:0]                  in_valid_s;
    logic [SNACK_W-1:0]          in_data_s [2];
    logic [SNACK_W-1:0]          mem_q [2][IN_DEPTH];
    logic [PW-1:0]               wr_q [2];
    logic [PW-1:0]               wr_d [2];
    logic [PW-1:0]               rd_q [2];
    logic [PW-1:0]               rd_d [2];
    logic [CW-1:0]               cnt_q [2];
    logic [CW-1:0]               cnt_d [2];
    logic [1:0]                  full_s;
    logic [1:0]                  empty_s;
    logic [1:0]                  push_s;
    logic [1:0]                  pop_s;
    logic [SNACK_W-1:0]          head_s [2];
    logic [2:0]                  dst_s [2];
    logic [7:0]                  gnt0_s;
    logic [7:0]                  gnt1_s;
    logic [7:0]                  ov_q;
    logic [7:0]                  ov_d;
    logic [7:0]                  rr_q;
    logic [7:0]                  rr_d;
    logic [7:0][SNACK_W-1:0]     od_q;
    logic [7:0][SNACK_W-1:0]     od_d;

    assign in_valid_s   = {dr1tol2_snack_valid, dr0tol2_snack_valid};
    assign in_data_s[0] = dr0tol2_snack;
    assign in_data_s[1] = dr1tol2_snack;

    // Retry comes from the registered occupancy only.
    assign dr0tol2_snack_retry = full_s[0];
    assign dr1tol2_snack_retry = full_s[1];
    assign drtol2_snack_valid  = ov_q;
    assign drtol2_snack        = od_q;

    // FIFO status, accepted pushes and head decode
    always_comb begin
        full_s  = 2'b00;
        empty_s = 2'b00;
        push_s  = 2'b00;
        for (int i = 0; i < 2; i++) begin
            full_s[i]  = (cnt_q[i] == FULL_CNT);
            empty_s[i] = (cnt_q[i] == CW'(0));
            push_s[i]  = in_valid_s[i] & ~full_s[i];
            head_s[i]  = mem_q[i][rd_q[i]];
            dst_s[i]   = head_s[i][DST_LSB +: 3];
        end
    end

    // Per-pipe round-robin grant; rr_q[j]=0 favours dr0 on a tie
    always_comb begin
        logic c0;
        logic c1;
        logic ld;
        gnt0_s = 8'h00;
        gnt1_s = 8'h00;
        c0 = 1'b0;
        c1 = 1'b0;
        ld = 1'b0;
        for (int j = 0; j < 8; j++) begin
            c0 = ~empty_s[0] && (dst_s[0] == 3'(j));
            c1 = ~empty_s[1] && (dst_s[1] == 3'(j));
            ld = ~ov_q[j] | ~drtol2_snack_retry[j];
            if (ld) begin
                gnt0_s[j] = c0 & (~c1 | ~rr_q[j]);
                gnt1_s[j] = c1 & (~c0 | rr_q[j]);
            end else begin
                gnt0_s[j] = 1'b0;
                gnt1_s[j] = 1'b0;
            end
        end
        pop_s = {|gnt1_s, |gnt0_s};
    end

    // Next-state for FIFO pointers/counts and output registers
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            wr_d[i]  = wr_q[i];
            rd_d[i]  = rd_q[i];
            cnt_d[i] = cnt_q[i];
            if (push_s[i]) begin
                wr_d[i] = wr_q[i] + PW'(1);
            end else begin
                wr_d[i] = wr_q[i];
            end
            if (pop_s[i]) begin
                rd_d[i] = rd_q[i] + PW'(1);
            end else begin
                rd_d[i] = rd_q[i];
            end
            case ({push_s[i], pop_s[i]})
                2'b10:   cnt_d[i] = cnt_q[i] + CW'(1);
                2'b01:   cnt_d[i] = cnt_q[i] - CW'(1);
                default: cnt_d[i] = cnt_q[i];
            endcase
        end
        ov_d = ov_q;
        od_d = od_q;
        rr_d = rr_q;
        for (int j = 0; j < 8; j++) begin
            if (gnt0_s[j] | gnt1_s[j]) begin
                ov_d[j] = 1'b1;
                od_d[j] = gnt1_s[j] ? head_s[1] : head_s[0];
                rr_d[j] = gnt0_s[j];
            end else if (~drtol2_snack_retry[j]) begin
                ov_d[j] = 1'b0;
            end else begin
                ov_d[j] = ov_q[j];
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                wr_q[i]  <= '0;
                rd_q[i]  <= '0;
                cnt_q[i] <= '0;
            end
            ov_q <= 8'h00;
            rr_q <= 8'h00;
            od_q <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                wr_q[i]  <= wr_d[i];
                rd_q[i]  <= rd_d[i];
                cnt_q[i] <= cnt_d[i];
            end
            ov_q <= ov_d;
            rr_q <= rr_d;
            od_q <= od_d;
        end
    end

    // FIFO storage; contents are don't-care while the count says empty
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (push_s[i]) begin
                mem_q[i][wr_q[i]] <= in_data_s[i];
            end
        end
    end

endmodule
